// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle for the memory-stage SRAM controller.
// Carries the EXE/MEM request side, the result/freeze going back to the
// pipeline, and the 16-bit asynchronous SRAM bus.
//   master : the environment (pipeline registers plus the external SRAM)
//   slave  : the controller itself
interface mem_stage_sram_ctrl_if #(
    parameter int SRAM_ADDR_W = 18
);
    // Pipeline side
    logic                   mem_r_en_in_mem;
    logic                   mem_w_en_in_mem;
    logic [31:0]            addr_in;
    logic [31:0]            st_val;
    logic                   mem_ready;
    logic [31:0]            mem_read_data;

    // SRAM side
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic                   sram_we_n;
    logic [15:0]            sram_dq_out;
    logic                   sram_dq_oe;
    logic [15:0]            sram_dq_in;

    modport master (
        output mem_r_en_in_mem,
        output mem_w_en_in_mem,
        output addr_in,
        output st_val,
        output sram_dq_in,
        input  mem_ready,
        input  mem_read_data,
        input  sram_addr,
        input  sram_we_n,
        input  sram_dq_out,
        input  sram_dq_oe
    );

    modport slave (
        input  mem_r_en_in_mem,
        input  mem_w_en_in_mem,
        input  addr_in,
        input  st_val,
        input  sram_dq_in,
        output mem_ready,
        output mem_read_data,
        output sram_addr,
        output sram_we_n,
        output sram_dq_out,
        output sram_dq_oe
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage SRAM controller.
// Splits each 32-bit load/store into two 16-bit accesses (low half first) on
// an external asynchronous SRAM, holding every half on the bus for
// WAIT_CYCLES+1 cycles. mem_ready drops while an access is in flight so the
// whole pipeline freezes; the request inputs are held stable meanwhile.
// A store wins when both enables are set.
//
// Optional feature, enabled by defining MEM_LAST_READ_HIT_EN:
//   a one-entry buffer remembers the word index of the last completed read;
//   a repeated read of that word skips the SRAM and completes in 2 cycles
//   with mem_read_data unchanged. A store to that word invalidates it.
module mem_stage_sram_ctrl #(
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_stage_sram_ctrl_if.slave bus
);

    localparam int IDX_W = SRAM_ADDR_W - 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [15:0]        lo_hold;
    logic [31:0]        rd_data;

    // Decoded request
    logic               req;
    logic               is_wr;
    logic               is_rd;
    logic [IDX_W-1:0]   word_idx;
    logic               half_done;
    logic               hit;

    // Combinational outputs and strobes
    logic               ready_c;
    logic [SRAM_ADDR_W-1:0] sram_addr_c;
    logic               sram_we_n_c;
    logic               sram_dq_oe_c;
    logic [15:0]        sram_dq_out_c;
    logic               lo_cap;
    logic               rd_done;
    logic               wr_done;

    // Byte-address bits outside the word index never reach the SRAM.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_in[31:SRAM_ADDR_W+1], bus.addr_in[1:0]};

    assign req       = bus.mem_r_en_in_mem | bus.mem_w_en_in_mem;
    assign is_wr     = bus.mem_w_en_in_mem;
    assign is_rd     = bus.mem_r_en_in_mem & ~bus.mem_w_en_in_mem;
    assign word_idx  = bus.addr_in[SRAM_ADDR_W:2];
    assign half_done = (cnt == CNT_MAX);

`ifdef MEM_LAST_READ_HIT_EN
    logic               buf_valid;
    logic [IDX_W-1:0]   buf_tag;

    assign hit = is_rd & buf_valid & (buf_tag == word_idx);

    // Track the word index of the last completed read; stores to it invalidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
        end else if (rd_done) begin
            buf_valid <= 1'b1;
            buf_tag   <= word_idx;
        end else if (wr_done && (buf_tag == word_idx)) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // State and wait-counter register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and they all update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic plus Moore-style bus drive for the current half.
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ready_c       = 1'b0;
        sram_addr_c   = '0;
        sram_we_n_c   = 1'b1;
        sram_dq_oe_c  = 1'b0;
        sram_dq_out_c = '0;
        lo_cap        = 1'b0;
        rd_done       = 1'b0;
        wr_done       = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = hit ? DONE : LO;
                    cnt_nxt   = '0;
                end else begin
                    ready_c   = 1'b1;
                end
            end

            LO: begin
                sram_addr_c = {word_idx, 1'b0};
                if (is_wr) begin
                    sram_we_n_c   = 1'b0;
                    sram_dq_oe_c  = 1'b1;
                    sram_dq_out_c = bus.st_val[15:0];
                end
                if (half_done) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                    lo_cap    = is_rd;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end

            HI: begin
                sram_addr_c = {word_idx, 1'b1};
                if (is_wr) begin
                    sram_we_n_c   = 1'b0;
                    sram_dq_oe_c  = 1'b1;
                    sram_dq_out_c = bus.st_val[31:16];
                end
                if (half_done) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    rd_done   = is_rd;
                    wr_done   = is_wr;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end

            DONE: begin
                // Pipeline advances on this edge; never re-arm on a held request.
                ready_c   = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Capture the two read halves; the result register only moves when a read completes.
    // NOTE: the low holding register is reset as well, so nothing in the
    // datapath comes out of reset undefined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_hold <= '0;
            rd_data <= '0;
        end else begin
            if (lo_cap) begin
                lo_hold <= bus.sram_dq_in;
            end
            if (rd_done) begin
                rd_data <= {bus.sram_dq_in, lo_hold};
            end
        end
    end

    assign bus.mem_ready     = ready_c;
    assign bus.mem_read_data = rd_data;
    assign bus.sram_addr     = sram_addr_c;
    assign bus.sram_we_n     = sram_we_n_c;
    assign bus.sram_dq_oe    = sram_dq_oe_c;
    assign bus.sram_dq_out   = sram_dq_out_c;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl.
// A word-level reference memory predicts every transaction's result, its
// freeze length and its SRAM bus activity; a monitor compares them as the
// DUT completes. Define MEM_LAST_READ_HIT_EN to exercise the read buffer.
module tb_mem_stage_sram_ctrl;

    localparam int SRAM_ADDR_W = 18;
    localparam int WAIT_CYCLES = 1;
    localparam int HALF_CYC    = WAIT_CYCLES + 1;
    localparam int MISS_LAT    = 1 + 2 * HALF_CYC;

    typedef struct {
        logic                   is_wr;
        logic [SRAM_ADDR_W-2:0] idx;
        logic [31:0]            st;
        logic [31:0]            rdata;
        int                     lat;
        int                     act;
    } exp_t;

    logic clk;
    logic rst;

    mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(SRAM_ADDR_W)) bus ();

    mem_stage_sram_ctrl #(
        .SRAM_ADDR_W(SRAM_ADDR_W),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SRAM model: 1024 half-words are enough for word indices < 512.
    logic [15:0] sram_mem [0:1023];
    assign bus.sram_dq_in = sram_mem[bus.sram_addr[9:0]];

    initial begin : sram_write
        forever begin
            @(posedge clk);
            if (!bus.sram_we_n) sram_mem[bus.sram_addr[9:0]] = bus.sram_dq_out;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:511];
    logic [31:0] last_rd;
    logic        hit_valid;
    int          hit_tag;
    exp_t        exp_q [$];
    bit          sb_en;

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict the outcome of one pipeline request and queue it.
    task automatic push_exp(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        idx     = int'(a[SRAM_ADDR_W:2]);
        e.is_wr = w;
        e.idx   = a[SRAM_ADDR_W:2];
        e.st    = d;
        e.lat   = MISS_LAT;
        e.act   = 2 * HALF_CYC;
        if (w) begin
            ref_mem[idx] = d;
            e.rdata = last_rd;
            if (hit_tag == idx) hit_valid = 1'b0;
        end else begin
`ifdef MEM_LAST_READ_HIT_EN
            if (hit_valid && hit_tag == idx) begin
                e.lat = 1;
                e.act = 0;
            end
`endif
            if (r) last_rd = ref_mem[idx];
            e.rdata   = last_rd;
            hit_valid = 1'b1;
            hit_tag   = idx;
        end
        exp_q.push_back(e);
    endtask

    // Issue one request (called just after a rising edge) and wait for its DONE edge.
    task automatic do_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        push_exp(r, w, a, d);
        bus.mem_r_en_in_mem = r;
        bus.mem_w_en_in_mem = w;
        bus.addr_in         = a;
        bus.st_val          = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_ready && n < 40);
        check("ready_timeout", {31'd0, bus.mem_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.mem_r_en_in_mem = 1'b0;
        bus.mem_w_en_in_mem = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle bus checks and per-transaction scoreboard compare.
    initial begin : monitor
        int   low_cnt;
        int   act;
        exp_t e;
        low_cnt = 0;
        act     = 0;
        forever begin
            @(negedge clk);
            if (rst || !sb_en) begin
                low_cnt = 0;
                act     = 0;
            end else if (!(bus.mem_r_en_in_mem || bus.mem_w_en_in_mem)) begin
                check("idle_ready", {31'd0, bus.mem_ready}, 32'd1);
                check("idle_we_n",  {31'd0, bus.sram_we_n}, 32'd1);
                check("idle_oe",    {31'd0, bus.sram_dq_oe}, 32'd0);
            end else begin
                check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    if (!bus.mem_ready) begin
                        low_cnt++;
                        if (bus.sram_addr != '0) begin
                            check("half_order", {31'd0, bus.sram_addr[0]}, {31'd0, act >= HALF_CYC});
                            check("word_idx", 32'(bus.sram_addr[SRAM_ADDR_W-1:1]), 32'(e.idx));
                            if (e.is_wr) begin
                                check("wr_we_n", {31'd0, bus.sram_we_n}, 32'd0);
                                check("wr_oe",   {31'd0, bus.sram_dq_oe}, 32'd1);
                                check("wr_dq", {16'd0, bus.sram_dq_out},
                                      {16'd0, bus.sram_addr[0] ? e.st[31:16] : e.st[15:0]});
                            end else begin
                                check("rd_we_n", {31'd0, bus.sram_we_n}, 32'd1);
                                check("rd_oe",   {31'd0, bus.sram_dq_oe}, 32'd0);
                            end
                            act++;
                        end else begin
                            check("req_idle_we_n", {31'd0, bus.sram_we_n}, 32'd1);
                            check("req_idle_oe",   {31'd0, bus.sram_dq_oe}, 32'd0);
                        end
                    end else begin
                        check("latency",    low_cnt, e.lat);
                        check("bus_cycles", act, e.act);
                        check("read_data",  bus.mem_read_data, e.rdata);
                        check("done_addr",  32'(bus.sram_addr), 32'd0);
                        void'(exp_q.pop_front());
                        low_cnt = 0;
                        act     = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          n;
        int          idx;
        int          kind;
        logic [31:0] a;
        n_checks  = 0;
        n_errors  = 0;
        sb_en     = 1'b0;
        last_rd   = '0;
        hit_valid = 1'b0;
        hit_tag   = -1;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = $urandom;
        end
        ref_mem[4] = 32'h5678_1234;
        for (int i = 0; i < 512; i++) begin
            sram_mem[2*i]   = ref_mem[i][15:0];
            sram_mem[2*i+1] = ref_mem[i][31:16];
        end

        rst                 = 1'b1;
        bus.mem_r_en_in_mem = 1'b0;
        bus.mem_w_en_in_mem = 1'b0;
        bus.addr_in         = '0;
        bus.st_val          = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'd0, bus.mem_ready}, 32'd1);
        check("rst_we_n",   {31'd0, bus.sram_we_n}, 32'd1);
        check("rst_oe",     {31'd0, bus.sram_dq_oe}, 32'd0);
        check("rst_dq_out", {16'd0, bus.sram_dq_out}, 32'd0);
        check("rst_addr",   32'(bus.sram_addr), 32'd0);
        check("rst_rdata",  bus.mem_read_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // Directed: load, back-to-back store, both enables, reload, repeat load.
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        do_txn(1'b1, 1'b1, 32'h0000_0020, 32'h0000_00AA);
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        idle(2);

        // Randomized traffic, biased to a few words so hits and invalidations occur.
        for (int t = 0; t < 150; t++) begin
            idx  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : $urandom_range(1, 511);
            a    = ($urandom & ~32'h0007_FFFC) | (32'(idx) << 2);
            kind = $urandom_range(0, 9);
            if (kind < 4)      do_txn(1'b1, 1'b0, a, $urandom);
            else if (kind < 8) do_txn(1'b0, 1'b1, a, $urandom);
            else               do_txn(1'b1, 1'b1, a, $urandom);
            idle($urandom_range(0, 2));
        end

        // Prepare reset test: word 17 invalid in the buffer, result register loaded.
        do_txn(1'b0, 1'b1, 32'h0000_0044, $urandom);
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        idle(1);

        // Reset in the middle of the high half of a read.
        sb_en               = 1'b0;
        bus.mem_r_en_in_mem = 1'b1;
        bus.addr_in         = 32'h0000_0044;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.sram_addr[0] == 1'b1) && n < 20);
        check("reach_hi", {31'd0, bus.sram_addr[0]}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_we_n",  {31'd0, bus.sram_we_n}, 32'd1);
        check("midrst_oe",    {31'd0, bus.sram_dq_oe}, 32'd0);
        check("midrst_addr",  32'(bus.sram_addr), 32'd0);
        check("midrst_rdata", bus.mem_read_data, 32'd0);
        check("midrst_ready", {31'd0, bus.mem_ready}, 32'd0);
        bus.mem_r_en_in_mem = 1'b0;
        #1;
        check("midrst_ready_idle", {31'd0, bus.mem_ready}, 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        last_rd   = '0;
        hit_valid = 1'b0;
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // After reset the buffer is empty: this must be a full miss.
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        idle(3);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
